seq_tx: RTL

Serial frame transmitter that drives the single-bit stream consumed by the team's "010" sequence-detector (Mealy) block. It accepts a parallel data word through a valid/ready handshake, then emits a fixed 3-bit sync preamble `010` followed by the word MSB-first, one bit per clock. Between frames it holds the line idle-high, so the detector never sees a false preamble on an idle line. It sits at the stimulus/transmit end of the serial link, directly driving the detector's `din`.

---
 rtl/seq_pkg.sv | 15 +
 rtl/piso_shift.sv | 26 ++
 rtl/seq_tx.sv | 102 ++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared constants for the "010" serial link: FSM states, sync preamble and idle line level.
// The transmitter and the detector both use these values.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PRE  = 2'b01,
        DATA = 2'b10
    } state_t;

    localparam int               PRE_LEN    = 3;
    localparam logic [PRE_LEN-1:0] PREAMBLE = 3'b010;
    localparam logic             IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/piso_shift.sv
// Parallel-in/serial-out register. It loads a word and shifts left with the MSB first.
// It exposes the current MSB and the next bit, so the caller can register the line one cycle ahead.
module piso_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_msb,
    output logic             o_nxt
);

    logic [WIDTH-1:0] r_sh;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         r_sh <= '0;
        else if (i_load)  r_sh <= i_data;
        else if (i_shift) r_sh <= {r_sh[WIDTH-2:0], 1'b0};
    end

    assign o_msb = r_sh[WIDTH-1];
    assign o_nxt = r_sh[WIDTH-2];

endmodule

// File: rtl/seq_tx.sv
// Serial frame transmitter. It sends the preamble 010 and then the data word MSB-first.
// The line idles high between frames.
module seq_tx
    import seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din_data,
    input  logic             din_vld,
    output logic             din_rdy,
    output logic             dout,
    output logic             dout_vld,
    output logic             busy
);

    localparam int             CW        = $clog2(WIDTH + 3);
    localparam logic [CW-1:0]  PRE_LAST  = CW'(PRE_LEN - 1);
    localparam logic [CW-1:0]  DATA_LAST = CW'(WIDTH - 1);

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_dout, r_dout_vld, r_busy;
    logic          w_dout_nxt, w_pre_bit;
    logic          w_load, w_shift, w_msb, w_nxt;

    piso_shift #(.WIDTH(WIDTH)) u_piso (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (din_data),
        .o_msb   (w_msb),
        .o_nxt   (w_nxt)
    );

    // The line outputs are registered from the next state, so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_dout     <= IDLE_LEVEL;
            r_dout_vld <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_dout     <= w_dout_nxt;
            r_dout_vld <= (w_state_nxt != IDLE);
            r_busy     <= (w_state_nxt != IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: if (din_vld) begin
                w_state_nxt = PRE;
                w_cnt_nxt   = '0;
            end
            PRE: if (r_cnt == PRE_LAST) begin
                w_state_nxt = DATA;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt   = r_cnt + CW'(1);
            end
            DATA: if (r_cnt == DATA_LAST) begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt   = r_cnt + CW'(1);
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_load    = (r_state == IDLE) && din_vld;
        w_shift   = (r_state == DATA);
        w_pre_bit = PREAMBLE[PRE_LEN-1];
        for (int i = 1; i < PRE_LEN; i++)
            if (w_cnt_nxt == CW'(i)) w_pre_bit = PREAMBLE[PRE_LEN-1-i];
        w_dout_nxt = IDLE_LEVEL;
        case (w_state_nxt)
            PRE:  w_dout_nxt = w_pre_bit;
            // On entry to DATA the word is unshifted. Later the shift register advances this same edge.
            DATA: w_dout_nxt = (r_state == PRE) ? w_msb : w_nxt;
            default: w_dout_nxt = IDLE_LEVEL;
        endcase
    end

    assign din_rdy  = (r_state == IDLE);
    assign dout     = r_dout;
    assign dout_vld = r_dout_vld;
    assign busy     = r_busy;

endmodule
